sdram_port_arbiter: RTL and testbench

- Two-master Avalon-MM arbiter in front of the single-port SDRAM controller slave (16-bit, 64 MB part).
- Master 0 is the video frame reader: read-only, bursting. Master 1 is the HPS/pixel-writer port: single-word read/write.
- Master-0 bursts are split into sequential single-word reads, because the controller has no burst support.
- A tag FIFO records the owner of every outstanding read so that read returns are routed back to the correct master.

---
 rtl/sdram_port_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-master Avalon-MM arbiter for the SDRAM controller (option: SDRAM_ARB_STATS_EN)
// Master 0 bursts are split into single reads; a tag FIFO routes read returns to their owner.

module sdram_arb_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_push_tag,
    input  logic          i_pop,
    output logic          o_head,
    output logic [CW-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_count;

    // Caller never pushes when full nor pops when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push)
                r_wr <= r_wr + 1'b1;
            if (i_pop)
                r_rd <= r_rd + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr] <= i_push_tag;
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;
endmodule

module sdram_port_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 16,
    parameter int BURST_W    = 4,
    parameter int PEND_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic [BURST_W-1:0] m0_burstcount,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [1:0]        m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [1:0]        s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,
    output logic              err_orphan
`ifdef SDRAM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_m0_words,
    output logic [31:0]       stat_m1_cmds,
    output logic [31:0]       stat_stall_cycles,
    output logic [4:0]        stat_max_pend
`endif
);
    localparam int CW = $clog2(PEND_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, M0_BURST, M1_XFER} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_last_grant;
    logic [ADDR_W-1:0]  r_base;
    logic [BURST_W-1:0] r_cnt;
    logic [BURST_W-1:0] r_idx;
    logic               r_err_orphan;

    logic [CW-1:0]      w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_head;
    logic               w_push;
    logic               w_push_tag;
    logic               w_pop;
    logic               w_m0_elig;
    logic               w_m1_elig;
    logic               w_grant_m0;
    logic               w_grant_m1;
    logic               w_beat;
    logic               w_m1_accept;
    logic [ADDR_W-1:0]  w_burst_addr;

    assign w_full    = (w_count == CW'(PEND_DEPTH));
    assign w_empty   = (w_count == '0);
    assign w_m0_elig = m0_read && !w_full;
    // A write needs no tag slot, so it stays eligible while the FIFO is full.
    assign w_m1_elig = m1_read ? !w_full : m1_write;

    assign w_pop            = s_readdatavalid && !w_empty;
    assign m0_readdatavalid = w_pop && !w_head;
    assign m1_readdatavalid = w_pop && w_head;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign err_orphan       = r_err_orphan;

    assign w_burst_addr = r_base + {{(ADDR_W-BURST_W){1'b0}}, r_idx};

    sdram_arb_tag_fifo #(
        .DEPTH (PEND_DEPTH),
        .CW    (CW)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (reset),
        .i_push     (w_push),
        .i_push_tag (w_push_tag),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_count)
    );

    always_comb begin
        w_state_next   = r_state;
        w_grant_m0     = 1'b0;
        w_grant_m1     = 1'b0;
        w_beat         = 1'b0;
        w_m1_accept    = 1'b0;
        w_push         = 1'b0;
        w_push_tag     = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_address      = w_burst_addr;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        case (r_state)
            IDLE: begin
                if (w_m1_elig && (!w_m0_elig || !r_last_grant)) begin
                    w_grant_m1   = 1'b1;
                    w_state_next = M1_XFER;
                end else if (w_m0_elig) begin
                    w_grant_m0     = 1'b1;
                    m0_waitrequest = 1'b0;
                    w_state_next   = M0_BURST;
                end
            end
            M0_BURST: begin
                s_read = !w_full;
                if (!w_full && !s_waitrequest) begin
                    w_beat = 1'b1;
                    w_push = 1'b1;
                    if (r_idx == r_cnt - 1'b1)
                        w_state_next = IDLE;
                end
            end
            M1_XFER: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write && !m1_read;
                m1_waitrequest = s_waitrequest;
                if (!m1_read && !m1_write) begin
                    w_state_next = IDLE;
                end else if (!s_waitrequest) begin
                    w_m1_accept  = 1'b1;
                    w_push       = m1_read;
                    w_push_tag   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_base       <= '0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_m0) begin
                r_base       <= m0_address;
                r_cnt        <= (m0_burstcount == '0) ? {{(BURST_W-1){1'b0}}, 1'b1} : m0_burstcount;
                r_idx        <= '0;
                r_last_grant <= 1'b0;
            end
            if (w_grant_m1)
                r_last_grant <= 1'b1;
            if (w_beat)
                r_idx <= r_idx + 1'b1;
            if (s_readdatavalid && w_empty)
                r_err_orphan <= 1'b1;
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    logic [31:0] r_stat_m0_words;
    logic [31:0] r_stat_m1_cmds;
    logic [31:0] r_stat_stall_cycles;
    logic [4:0]  r_stat_max_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_m0_words     <= '0;
            r_stat_m1_cmds      <= '0;
            r_stat_stall_cycles <= '0;
            r_stat_max_pend     <= '0;
        end else begin
            if (w_beat)
                r_stat_m0_words <= r_stat_m0_words + 1'b1;
            if (w_m1_accept)
                r_stat_m1_cmds <= r_stat_m1_cmds + 1'b1;
            if ((s_read || s_write) && s_waitrequest)
                r_stat_stall_cycles <= r_stat_stall_cycles + 1'b1;
            if (32'(w_count) > 32'(r_stat_max_pend))
                r_stat_max_pend <= 5'(w_count);
        end
    end

    assign stat_m0_words     = r_stat_m0_words;
    assign stat_m1_cmds      = r_stat_m1_cmds;
    assign stat_stall_cycles = r_stat_stall_cycles;
    assign stat_max_pend     = r_stat_max_pend;
`endif
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter

module tb_sdram_port_arbiter;
    logic        clk;
    logic        reset;
    logic [24:0] m0_address;
    logic        m0_read;
    logic [3:0]  m0_burstcount;
    logic        m0_waitrequest;
    logic [15:0] m0_readdata;
    logic        m0_readdatavalid;
    logic [24:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [15:0] m1_writedata;
    logic [1:0]  m1_byteenable;
    logic        m1_waitrequest;
    logic [15:0] m1_readdata;
    logic        m1_readdatavalid;
    logic [24:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [15:0] s_writedata;
    logic [1:0]  s_byteenable;
    logic        s_waitrequest;
    logic [15:0] s_readdata;
    logic        s_readdatavalid;
    logic        err_orphan;

    typedef struct packed {
        logic        wr;
        logic [24:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
        logic        owner;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [15:0] exp_m0[$];
    logic [15:0] exp_m1[$];
    logic        tb_owner[$];

    int checks;
    int errors;

    logic        last_m0_wait;
    logic        last_m1_wait;
    logic        last_s_read;
    logic        last_s_acc;
    logic [24:0] last_s_addr;

    sdram_port_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_burstcount    (m0_burstcount),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid),
        .err_orphan       (err_orphan)
    );

    always #5 clk = ~clk;

    // One clock: observe at the falling edge, then return just after the rising edge.
    task automatic step();
        cmd_t        c;
        logic [15:0] d;
        @(negedge clk);
        last_m0_wait = m0_waitrequest;
        last_m1_wait = m1_waitrequest;
        last_s_read  = s_read;
        last_s_acc   = (s_read || s_write) && !s_waitrequest;
        last_s_addr  = s_address;
        if (last_s_acc) begin
            checks++;
            if (exp_cmd.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected got wr=%b addr=%h expected no command", s_write, s_address);
            end else begin
                c = exp_cmd.pop_front();
                if (s_write !== c.wr || s_address !== c.addr ||
                    (c.wr && (s_writedata !== c.data || s_byteenable !== c.be))) begin
                    errors++;
                    $display("FAIL cmd got wr=%b addr=%h data=%h be=%b expected wr=%b addr=%h data=%h be=%b",
                             s_write, s_address, s_writedata, s_byteenable, c.wr, c.addr, c.data, c.be);
                end
                if (!c.wr)
                    tb_owner.push_back(c.owner);
            end
        end
        if (m0_readdatavalid) begin
            checks++;
            if (exp_m0.size() == 0) begin
                errors++;
                $display("FAIL m0_rdv_unexpected got data=%h expected no pulse", m0_readdata);
            end else begin
                d = exp_m0.pop_front();
                if (m0_readdata !== d) begin
                    errors++;
                    $display("FAIL m0_data got %h expected %h", m0_readdata, d);
                end
            end
        end
        if (m1_readdatavalid) begin
            checks++;
            if (exp_m1.size() == 0) begin
                errors++;
                $display("FAIL m1_rdv_unexpected got data=%h expected no pulse", m1_readdata);
            end else begin
                d = exp_m1.pop_front();
                if (m1_readdata !== d) begin
                    errors++;
                    $display("FAIL m1_data got %h expected %h", m1_readdata, d);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic wr, input logic [24:0] a, input logic [15:0] d,
                            input logic [1:0] be, input logic owner);
        cmd_t c;
        c.wr = wr; c.addr = a; c.data = d; c.be = be; c.owner = owner;
        exp_cmd.push_back(c);
    endtask

    task automatic m0_burst(input logic [24:0] a, input logic [3:0] bc);
        int n;
        int beats;
        beats = (bc == 4'd0) ? 1 : int'(bc);
        for (int i = 0; i < beats; i++)
            push_cmd(1'b0, a + 25'(i), 16'h0, 2'b00, 1'b0);
        m0_address = a; m0_burstcount = bc; m0_read = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (last_m0_wait && n < 20);
        m0_read = 1'b0;
        checks++;
        if (last_m0_wait) begin
            errors++;
            $display("FAIL m0_grant_timeout got waitrequest=1 expected 0 within 20 cycles");
        end
    endtask

    task automatic m1_single(input logic wr, input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
        int n;
        push_cmd(wr, a, d, be, 1'b1);
        m1_address = a; m1_writedata = d; m1_byteenable = be;
        m1_read = !wr; m1_write = wr;
        n = 0;
        do begin
            step();
            n++;
        end while (last_m1_wait && n < 20);
        m1_read = 1'b0; m1_write = 1'b0;
        checks++;
        if (last_m1_wait) begin
            errors++;
            $display("FAIL m1_accept_timeout got waitrequest=1 expected 0 within 20 cycles");
        end
    endtask

    task automatic drive_pair(input logic [24:0] a0, input logic [3:0] bc, input logic wr1,
                              input logic [24:0] a1, input logic [15:0] d1,
                              output int m0_at, output int m1_at);
        m0_address = a0; m0_burstcount = bc; m0_read = 1'b1;
        m1_address = a1; m1_writedata = d1; m1_byteenable = 2'b11;
        m1_read = !wr1; m1_write = wr1;
        m0_at = -1; m1_at = -1;
        for (int n = 0; n < 30 && (m0_read || m1_read || m1_write); n++) begin
            step();
            if (m0_read && !last_m0_wait) begin
                m0_read = 1'b0;
                m0_at = n;
            end
            if ((m1_read || m1_write) && !last_m1_wait) begin
                m1_read = 1'b0; m1_write = 1'b0;
                m1_at = n;
            end
        end
        m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    endtask

    // Slave returns one word; the owner comes from the bench's own record of accepted reads.
    task automatic ret(input logic [15:0] d);
        logic o;
        if (tb_owner.size() != 0) begin
            o = tb_owner.pop_front();
            if (o) exp_m1.push_back(d);
            else   exp_m0.push_back(d);
        end
        s_readdata = d; s_readdatavalid = 1'b1;
        step();
        s_readdatavalid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks += 6;
        if (s_read !== 1'b0)           begin errors++; $display("FAIL reset_s_read got %b expected 0", s_read); end
        if (s_write !== 1'b0)          begin errors++; $display("FAIL reset_s_write got %b expected 0", s_write); end
        if (m0_waitrequest !== 1'b1)   begin errors++; $display("FAIL reset_m0_wait got %b expected 1", m0_waitrequest); end
        if (m1_waitrequest !== 1'b1)   begin errors++; $display("FAIL reset_m1_wait got %b expected 1", m1_waitrequest); end
        if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
            errors++; $display("FAIL reset_rdv got %b expected 00", {m0_readdatavalid, m1_readdatavalid});
        end
        if (err_orphan !== 1'b0)       begin errors++; $display("FAIL reset_err_orphan got %b expected 0", err_orphan); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset_priority();
        int m0_at;
        int m1_at;
        push_cmd(1'b0, 25'h10, 16'h0, 2'b00, 1'b0);
        push_cmd(1'b0, 25'h11, 16'h0, 2'b00, 1'b1);
        drive_pair(25'h10, 4'd1, 1'b0, 25'h11, 16'h0, m0_at, m1_at);
        checks++;
        if (!(m0_at >= 0 && m1_at > m0_at)) begin
            errors++; $display("FAIL reset_priority got m0_at=%0d m1_at=%0d expected m0 first", m0_at, m1_at);
        end
        step();
        ret(16'h00AA);
        ret(16'h00BB);
        step();
    endtask

    task automatic test_m0_burst();
        m0_burst(25'h100, 4'd4);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (last_s_acc !== 1'b1) begin
                errors++; $display("FAIL burst_beat%0d got accept=%b expected 1", i, last_s_acc);
            end
        end
        step();
        checks++;
        if (last_s_read !== 1'b0) begin errors++; $display("FAIL burst_end got s_read=%b expected 0", last_s_read); end
        for (int i = 0; i < 4; i++)
            ret(16'hA0 + 16'(i));
        step();
    endtask

    task automatic test_fairness();
        int m0_at;
        int m1_at;
        push_cmd(1'b1, 25'h20, 16'hBEEF, 2'b11, 1'b1);
        push_cmd(1'b0, 25'h200, 16'h0, 2'b00, 1'b0);
        drive_pair(25'h200, 4'd1, 1'b1, 25'h20, 16'hBEEF, m0_at, m1_at);
        checks++;
        if (!(m1_at >= 0 && m0_at > m1_at)) begin
            errors++; $display("FAIL fairness got m0_at=%0d m1_at=%0d expected m1 first", m0_at, m1_at);
        end
        repeat (2) step();
        ret(16'h5555);
        step();
    endtask

    task automatic test_interleave();
        m0_burst(25'h300, 4'd2);
        repeat (2) step();
        m1_single(1'b0, 25'h40, 16'h0, 2'b11);
        ret(16'h0011);
        ret(16'h0022);
        ret(16'h0033);
        step();
        checks++;
        if (exp_m0.size() != 0 || exp_m1.size() != 0 || exp_cmd.size() != 0) begin
            errors++;
            $display("FAIL interleave_drain got m0=%0d m1=%0d cmd=%0d left expected 0", exp_m0.size(), exp_m1.size(), exp_cmd.size());
        end
    endtask

    task automatic test_fifo_full();
        m0_burst(25'h400, 4'd15);
        repeat (15) step();
        m0_burst(25'h500, 4'd2);
        step();
        checks++;
        if (last_s_acc !== 1'b1) begin errors++; $display("FAIL full_16th got accept=%b expected 1", last_s_acc); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (last_s_read !== 1'b0) begin errors++; $display("FAIL full_stall%0d got s_read=%b expected 0", i, last_s_read); end
        end
        ret(16'h1000);
        checks++;
        if (last_s_read !== 1'b0) begin errors++; $display("FAIL full_ret_cycle got s_read=%b expected 0", last_s_read); end
        step();
        checks++;
        if (last_s_acc !== 1'b1) begin errors++; $display("FAIL full_resume got accept=%b expected 1", last_s_acc); end
        for (int i = 1; i <= 16; i++)
            ret(16'h1000 + 16'(i));
        step();
        checks++;
        if (err_orphan !== 1'b0) begin errors++; $display("FAIL full_no_orphan got %b expected 0", err_orphan); end
    endtask

    task automatic test_wrap();
        m0_burst(25'h1FFFFFE, 4'd3);
        repeat (3) step();
        checks++;
        if (last_s_addr !== 25'h0) begin errors++; $display("FAIL wrap_last got %h expected 0000000", last_s_addr); end
        for (int i = 0; i < 3; i++)
            ret(16'hC0 + 16'(i));
        m0_burst(25'h700, 4'd0);
        step();
        step();
        checks++;
        if (last_s_read !== 1'b0) begin errors++; $display("FAIL zero_count got s_read=%b expected 0", last_s_read); end
        ret(16'h0D0D);
        step();
    endtask

    task automatic test_orphan_reset();
        push_cmd(1'b0, 25'h600, 16'h0, 2'b00, 1'b0);
        push_cmd(1'b0, 25'h601, 16'h0, 2'b00, 1'b0);
        push_cmd(1'b0, 25'h602, 16'h0, 2'b00, 1'b0);
        m0_address = 25'h600; m0_burstcount = 4'd4; m0_read = 1'b1;
        step();
        m0_read = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        tb_owner.delete();
        step();
        checks++;
        if (last_s_read !== 1'b0) begin errors++; $display("FAIL reset_mid_burst got s_read=%b expected 0", last_s_read); end
        reset = 1'b0;
        step();
        checks++;
        if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_pre got %b expected 0", err_orphan); end
        ret(16'hDEAD);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky%0d got %b expected 1", i, err_orphan); end
            step();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_clear got %b expected 0", err_orphan); end
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1;
        m0_address = '0; m0_read = 1'b0; m0_burstcount = '0;
        m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
        checks = 0; errors = 0;
        test_reset();
        test_reset_priority();
        test_m0_burst();
        test_fairness();
        test_interleave();
        test_fifo_full();
        test_wrap();
        test_orphan_reset();
        checks++;
        if (exp_m0.size() != 0 || exp_m1.size() != 0 || exp_cmd.size() != 0) begin
            errors++;
            $display("FAIL final_drain got m0=%0d m1=%0d cmd=%0d left expected 0", exp_m0.size(), exp_m1.size(), exp_cmd.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
